// File: rtl/text_pkg.sv
// rtl/text_pkg.sv - shared geometry, control codes and state encodings for the text cursor writer
package text_pkg;

  localparam int ROW_NUMBER     = 16;
  localparam int COL_NUMBER     = 32;
  localparam int ROW_BIT_LEN    = 4;
  localparam int COL_BIT_LEN    = 5;
  localparam int CHAR_ID_LENGTH = 8;
  localparam int SWEEP_BIT_LEN  = ROW_BIT_LEN + COL_BIT_LEN;

  localparam logic [CHAR_ID_LENGTH-1:0] BLANK_ID = 8'h20;
  localparam logic [CHAR_ID_LENGTH-1:0] CC_BS    = 8'h08;
  localparam logic [CHAR_ID_LENGTH-1:0] CC_LF    = 8'h0A;
  localparam logic [CHAR_ID_LENGTH-1:0] CC_FF    = 8'h0C;
  localparam logic [CHAR_ID_LENGTH-1:0] CC_CR    = 8'h0D;
  localparam logic [CHAR_ID_LENGTH-1:0] CC_DEL   = 8'h7F;

  localparam logic [ROW_BIT_LEN-1:0]   ROW_LAST   = ROW_BIT_LEN'(ROW_NUMBER - 1);
  localparam logic [COL_BIT_LEN-1:0]   COL_LAST   = COL_BIT_LEN'(COL_NUMBER - 1);
  localparam logic [SWEEP_BIT_LEN-1:0] SWEEP_LAST = SWEEP_BIT_LEN'(ROW_NUMBER * COL_NUMBER - 1);

  typedef enum logic {
    ST_CLEAR,
    ST_IDLE
  } state_t;

  typedef enum logic [2:0] {
    BC_PRINT,
    BC_NEWLINE,
    BC_BACKSPACE,
    BC_FORMFEED,
    BC_IGNORE
  } byte_class_t;

  function automatic byte_class_t classify(input logic [CHAR_ID_LENGTH-1:0] b);
    byte_class_t bc;
    if (b == CC_LF || b == CC_CR)       bc = BC_NEWLINE;
    else if (b == CC_BS)                bc = BC_BACKSPACE;
    else if (b == CC_FF)                bc = BC_FORMFEED;
    else if (b < 8'h20 || b == CC_DEL)  bc = BC_IGNORE;
    else                                bc = BC_PRINT;
    return bc;
  endfunction

endpackage

// File: rtl/text_cursor_step.sv
// rtl/text_cursor_step.sv - next cursor positions for advance, newline and backspace with wrap
module text_cursor_step
  import text_pkg::*;
(
  input  logic [ROW_BIT_LEN-1:0] row,
  input  logic [COL_BIT_LEN-1:0] col,
  output logic [ROW_BIT_LEN-1:0] adv_row,
  output logic [COL_BIT_LEN-1:0] adv_col,
  output logic [ROW_BIT_LEN-1:0] nl_row,
  output logic [COL_BIT_LEN-1:0] nl_col,
  output logic [ROW_BIT_LEN-1:0] bs_row,
  output logic [COL_BIT_LEN-1:0] bs_col
);

  logic [ROW_BIT_LEN-1:0] row_inc;

  always_comb begin
    row_inc = (row == ROW_LAST) ? '0 : row + 1'b1;

    nl_row = row_inc;
    nl_col = '0;

    adv_row = row;
    adv_col = col + 1'b1;
    if (col == COL_LAST) begin
      adv_row = row_inc;
      adv_col = '0;
    end

    // Backspace stops at the home cell rather than wrapping to the bottom-right.
    bs_row = row;
    bs_col = col - 1'b1;
    if (col == '0) begin
      if (row == '0) begin
        bs_row = '0;
        bs_col = '0;
      end else begin
        bs_row = row - 1'b1;
        bs_col = COL_LAST;
      end
    end
  end

endmodule

// File: rtl/text_cursor_writer.sv
// rtl/text_cursor_writer.sv - byte stream to single-cell character plane writes at a tracked cursor
module text_cursor_writer
  import text_pkg::*;
(
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [CHAR_ID_LENGTH-1:0] char_in,
  input  logic                      char_valid,
  output logic                      char_ready,
  output logic                      wr_en,
  output logic [ROW_BIT_LEN-1:0]    wr_row,
  output logic [COL_BIT_LEN-1:0]    wr_col,
  output logic [CHAR_ID_LENGTH-1:0] wr_char,
  output logic [ROW_BIT_LEN-1:0]    cursor_row,
  output logic [COL_BIT_LEN-1:0]    cursor_col
);

  state_t                   state;
  logic [SWEEP_BIT_LEN-1:0] sweep;

  logic [ROW_BIT_LEN-1:0] adv_row, nl_row, bs_row;
  logic [COL_BIT_LEN-1:0] adv_col, nl_col, bs_col;
  logic                   accept;
  byte_class_t            bclass;

  text_cursor_step u_step (
    .row     (cursor_row),
    .col     (cursor_col),
    .adv_row (adv_row),
    .adv_col (adv_col),
    .nl_row  (nl_row),
    .nl_col  (nl_col),
    .bs_row  (bs_row),
    .bs_col  (bs_col)
  );

  assign char_ready = (state == ST_IDLE);
  assign accept     = char_valid && char_ready;
  assign bclass     = classify(char_in);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_CLEAR;
      sweep      <= '0;
      wr_en      <= 1'b0;
      wr_row     <= '0;
      wr_col     <= '0;
      wr_char    <= '0;
      cursor_row <= '0;
      cursor_col <= '0;
    end else begin
      case (state)
        ST_CLEAR: begin
          // Row-major sweep: the counter's upper bits are the row, lower bits the column.
          wr_en   <= 1'b1;
          wr_row  <= sweep[SWEEP_BIT_LEN-1:COL_BIT_LEN];
          wr_col  <= sweep[COL_BIT_LEN-1:0];
          wr_char <= BLANK_ID;
          if (sweep == SWEEP_LAST) begin
            sweep      <= '0;
            state      <= ST_IDLE;
            cursor_row <= '0;
            cursor_col <= '0;
          end else begin
            sweep <= sweep + 1'b1;
          end
        end

        ST_IDLE: begin
          wr_en <= 1'b0;
          if (accept) begin
            case (bclass)
              BC_PRINT: begin
                wr_en      <= 1'b1;
                wr_row     <= cursor_row;
                wr_col     <= cursor_col;
                wr_char    <= char_in;
                cursor_row <= adv_row;
                cursor_col <= adv_col;
              end
              BC_NEWLINE: begin
                cursor_row <= nl_row;
                cursor_col <= nl_col;
              end
              BC_BACKSPACE: begin
                wr_en      <= 1'b1;
                wr_row     <= bs_row;
                wr_col     <= bs_col;
                wr_char    <= BLANK_ID;
                cursor_row <= bs_row;
                cursor_col <= bs_col;
              end
              BC_FORMFEED: begin
                sweep <= '0;
                state <= ST_CLEAR;
              end
              default: ;
            endcase
          end
        end

        default: state <= ST_CLEAR;
      endcase
    end
  end

endmodule

// File: tb/tb_text_cursor_writer.sv
// tb/tb_text_cursor_writer.sv - directed self-checking bench for text_cursor_writer
module tb_text_cursor_writer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] char_in = 8'h00;
  logic       char_valid = 1'b0;
  logic       char_ready;
  logic       wr_en;
  logic [3:0] wr_row;
  logic [4:0] wr_col;
  logic [7:0] wr_char;
  logic [3:0] cursor_row;
  logic [4:0] cursor_col;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  text_cursor_writer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .char_in    (char_in),
    .char_valid (char_valid),
    .char_ready (char_ready),
    .wr_en      (wr_en),
    .wr_row     (wr_row),
    .wr_col     (wr_col),
    .wr_char    (wr_char),
    .cursor_row (cursor_row),
    .cursor_col (cursor_col)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // {wr_en, wr_row, wr_col, wr_char, cursor_row, cursor_col}
  function automatic logic [31:0] pack_out(input logic we, input logic [3:0] r, input logic [4:0] c,
                                           input logic [7:0] ch, input logic [3:0] cr,
                                           input logic [4:0] cc);
    return {5'd0, we, r, c, ch, cr, cc};
  endfunction

  function automatic logic [31:0] dut_out();
    return pack_out(wr_en, wr_row, wr_col, wr_char, cursor_row, cursor_col);
  endfunction

  // Write-side fields only matter when a write is expected.
  function automatic logic [31:0] dut_out_nowr();
    return pack_out(wr_en, 4'd0, 5'd0, 8'd0, cursor_row, cursor_col);
  endfunction

  task automatic send_wr(input string tag, input logic [7:0] b, input logic [3:0] r,
                         input logic [4:0] c, input logic [7:0] ch, input logic [3:0] cr,
                         input logic [4:0] cc);
    @(negedge clk);
    char_in = b;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    check(tag, dut_out(), pack_out(1'b1, r, c, ch, cr, cc));
  endtask

  task automatic send_nowr(input string tag, input logic [7:0] b, input logic [3:0] cr,
                           input logic [4:0] cc);
    @(negedge clk);
    char_in = b;
    char_valid = 1'b1;
    @(negedge clk);
    char_valid = 1'b0;
    check(tag, dut_out_nowr(), pack_out(1'b0, 4'd0, 5'd0, 8'd0, cr, cc));
  endtask

  task automatic sweep_check(input string tag, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check(tag, {12'd0, char_ready, wr_en, wr_row, wr_col, wr_char},
            {12'd0, (i == 511), 1'b1, 4'(i / 32), 5'(i % 32), 8'h20});
    end
  endtask

  initial begin
    logic [3:0] r;
    logic [4:0] c;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("reset_out", dut_out(), 32'd0);
    check("reset_ready", {31'd0, char_ready}, 32'd0);

    rst_n = 1'b1;
    sweep_check("power_sweep", 512);
    @(negedge clk);
    check("post_sweep", {char_ready, dut_out_nowr()}, {1'b1, pack_out(1'b0, 0, 0, 0, 0, 0)});

    // "AB" back-to-back
    char_in = 8'h41;
    char_valid = 1'b1;
    @(negedge clk);
    check("ab_A", dut_out(), pack_out(1'b1, 4'd0, 5'd0, 8'h41, 4'd0, 5'd1));
    char_in = 8'h42;
    @(negedge clk);
    char_valid = 1'b0;
    check("ab_B", dut_out(), pack_out(1'b1, 4'd0, 5'd1, 8'h42, 4'd0, 5'd2));
    @(negedge clk);
    check("ab_idle", {31'd0, wr_en}, 32'd0);

    // Backspace back to home, then at home
    send_wr("bs_1", 8'h08, 4'd0, 5'd1, 8'h20, 4'd0, 5'd1);
    send_wr("bs_0", 8'h08, 4'd0, 5'd0, 8'h20, 4'd0, 5'd0);
    send_wr("bs_home", 8'h08, 4'd0, 5'd0, 8'h20, 4'd0, 5'd0);

    // 32 printable bytes fill row 0; the last wraps cursor to (1,0)
    for (int i = 0; i < 32; i++) begin
      if (i == 31) send_wr("line_wrap", 8'h61, 4'd0, 5'd31, 8'h61, 4'd1, 5'd0);
      else         send_wr("line_fill", 8'h61, 4'd0, 5'(i), 8'h61, 4'd0, 5'(i + 1));
    end

    // Down to row 15, fill to col 31, then the screen wrap
    for (int i = 2; i <= 15; i++) send_nowr("lf_down", 8'h0A, 4'(i), 5'd0);
    for (int i = 0; i < 31; i++) send_wr("row15", 8'h80, 4'd15, 5'(i), 8'h80, 4'd15, 5'(i + 1));
    send_wr("screen_wrap", 8'hFF, 4'd15, 5'd31, 8'hFF, 4'd0, 5'd0);

    // Backspace at (3,0) crosses to previous row
    for (int i = 1; i <= 3; i++) send_nowr("lf_to3", 8'h0A, 4'(i), 5'd0);
    send_wr("bs_row", 8'h08, 4'd2, 5'd31, 8'h20, 4'd2, 5'd31);

    // Move to (15,7); CR wraps the row; ignored codes leave the cursor alone
    send_nowr("lf_wrapcol", 8'h0A, 4'd3, 5'd0);
    for (int i = 4; i <= 15; i++) send_nowr("lf_to15", 8'h0A, 4'(i), 5'd0);
    for (int i = 0; i < 7; i++) send_wr("to_col7", 8'h7E, 4'd15, 5'(i), 8'h7E, 4'd15, 5'(i + 1));
    send_nowr("cr_wrap", 8'h0D, 4'd0, 5'd0);
    r = 4'd0;
    c = 5'd0;
    send_nowr("bel_ignored", 8'h07, r, c);
    send_nowr("del_ignored", 8'h7F, r, c);
    send_nowr("nul_ignored", 8'h00, r, c);

    // Form feed, reset at sweep cycle 100, full sweep again; held byte lands after it
    @(negedge clk);
    char_in = 8'h0C;
    char_valid = 1'b1;
    @(negedge clk);
    char_in = 8'h51;
    check("ff_start", {char_ready, dut_out_nowr()}, {1'b0, pack_out(1'b0, 0, 0, 0, 0, 0)});
    sweep_check("ff_sweep", 100);
    rst_n = 1'b0;
    @(negedge clk);
    check("midclr_reset", {char_ready, dut_out()}, 33'd0);
    rst_n = 1'b1;
    sweep_check("restart_sweep", 512);
    @(negedge clk);
    char_valid = 1'b0;
    check("held_byte", dut_out(), pack_out(1'b1, 4'd0, 5'd0, 8'h51, 4'd0, 5'd1));
    @(negedge clk);
    check("held_once", {31'd0, wr_en}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
